// File: rtl/llc_cmd_dispatcher.sv
// llc_cmd_dispatcher: front end of the LLC model. Filters illegal trace
// commands, buffers legal {cmd, address} entries in an in-order FIFO, presents
// the head split into tag/index/offset over valid/ready, and keeps saturating
// per-class dispatch statistics (cleared when a CLR command is dispatched).
module llc_cmd_dispatcher #(
    parameter int DEPTH    = 4,
    parameter int ADDR_W   = 32,
    parameter int OFFSET_W = 6,
    parameter int INDEX_W  = 15,
    parameter int TAG_W    = ADDR_W - INDEX_W - OFFSET_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [3:0]          in_cmd,
    input  logic [ADDR_W-1:0]   in_addr,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [3:0]          out_cmd,
    output logic [TAG_W-1:0]    out_tag,
    output logic [INDEX_W-1:0]  out_index,
    output logic [OFFSET_W-1:0] out_offset,
    output logic                out_is_snoop,
    output logic                err_pulse,
    output logic [7:0]          err_count,
    output logic [15:0]         rd_count,
    output logic [15:0]         wr_count,
    output logic [15:0]         snp_count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;
    // tag, index and offset together are exactly the address, so an entry
    // stores the command plus the whole address and fields are sliced on read.
    localparam int ENT_W = 4 + ADDR_W;

    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [OCC_W-1:0] OCC_ONE  = OCC_W'(1);
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);
    localparam logic [3:0]       CMD_CLR  = 4'd8;

    // Legal codes are 0..6, 8 (CLR) and 9 (PRINT).
    function automatic logic cmd_is_legal(input logic [3:0] cmd);
        logic legal;
        case (cmd)
            4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9: legal = 1'b1;
            default: legal = 1'b0;
        endcase
        return legal;
    endfunction

    function automatic logic cmd_is_snoop(input logic [3:0] cmd);
        return (cmd >= 4'd3) && (cmd <= 4'd6);
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [ENT_W-1:0] mem_q [DEPTH];
    logic [ENT_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic             err_pulse_q, err_pulse_d;
    logic [7:0]       err_count_q, err_count_d;
    logic [15:0]      rd_count_q, rd_count_d;
    logic [15:0]      wr_count_q, wr_count_d;
    logic [15:0]      snp_count_q, snp_count_d;

    logic             full_s;
    logic             empty_s;
    logic [ENT_W-1:0] head_s;
    logic [3:0]       head_cmd_s;
    logic             accept_s;
    logic             push_s;
    logic             pop_s;

    assign full_s     = (occ_q >= OCC_FULL);
    assign empty_s    = (occ_q == '0);
    assign head_s     = mem_q[rd_ptr_q];
    assign head_cmd_s = head_s[ENT_W-1 -: 4];

    assign in_ready  = !full_s;
    assign out_valid = !empty_s;
    assign err_pulse = err_pulse_q;
    assign err_count = err_count_q;
    assign rd_count  = rd_count_q;
    assign wr_count  = wr_count_q;
    assign snp_count = snp_count_q;

    // Head-entry presentation; zeros whenever the FIFO is empty.
    always_comb begin
        out_cmd      = 4'd0;
        out_tag      = '0;
        out_index    = '0;
        out_offset   = '0;
        out_is_snoop = 1'b0;
        if (!empty_s) begin
            out_cmd      = head_cmd_s;
            out_tag      = head_s[ADDR_W-1 -: TAG_W];
            out_index    = head_s[OFFSET_W +: INDEX_W];
            out_offset   = head_s[OFFSET_W-1:0];
            out_is_snoop = cmd_is_snoop(head_cmd_s);
        end else begin
            out_cmd      = 4'd0;
            out_is_snoop = 1'b0;
        end
    end

    // FIFO next state: handshakes, storage write, pointers and occupancy.
    always_comb begin
        accept_s = in_valid && !full_s;
        push_s   = accept_s && cmd_is_legal(in_cmd);
        pop_s    = !empty_s && out_ready;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_s) begin
            mem_d[wr_ptr_q] = {in_cmd, in_addr};
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   occ_d = occ_q + OCC_ONE;
            2'b01:   occ_d = occ_q - OCC_ONE;
            default: occ_d = occ_q;
        endcase
    end

    // Statistics next state: error tracking on accept, class counters on dispatch.
    always_comb begin
        err_pulse_d = accept_s && !cmd_is_legal(in_cmd);
        err_count_d = err_count_q;
        rd_count_d  = rd_count_q;
        wr_count_d  = wr_count_q;
        snp_count_d = snp_count_q;
        if (err_pulse_d && (err_count_q != 8'hFF)) begin
            err_count_d = err_count_q + 8'd1;
        end else begin
            err_count_d = err_count_q;
        end
        if (pop_s) begin
            case (head_cmd_s)
                4'd0, 4'd2:             rd_count_d  = sat_inc16(rd_count_q);
                4'd1:                   wr_count_d  = sat_inc16(wr_count_q);
                4'd3, 4'd4, 4'd5, 4'd6: snp_count_d = sat_inc16(snp_count_q);
                CMD_CLR: begin
                    rd_count_d  = 16'd0;
                    wr_count_d  = 16'd0;
                    snp_count_d = 16'd0;
                end
                default:                rd_count_d  = rd_count_q;
            endcase
        end else begin
            rd_count_d = rd_count_q;
        end
    end

    // State registers with asynchronous active-high reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            occ_q       <= '0;
            err_pulse_q <= 1'b0;
            err_count_q <= 8'd0;
            rd_count_q  <= 16'd0;
            wr_count_q  <= 16'd0;
            snp_count_q <= 16'd0;
        end else begin
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            occ_q       <= occ_d;
            err_pulse_q <= err_pulse_d;
            err_count_q <= err_count_d;
            rd_count_q  <= rd_count_d;
            wr_count_q  <= wr_count_d;
            snp_count_q <= snp_count_d;
        end
    end

endmodule
